register_block: RTL and testbench
=================================

Name: register_block

Overview:
- Per-lane, warp-banked general-purpose register file for a 16-lane SIMT core.
- Each lane holds NUM_WARPS x NUM_REGS words of DATA_W bits. warp_selector chooses the active warp bank for all reads and writes.
- One write port: a shared waddr with per-lane data and per-lane enables.
- Two read ports (port 0, port 1): each has a shared address and per-lane enables. Sits between operand fetch and the writeback stage.

Parameters:
- NUM_LANES, 16, number of SIMD lanes. Port list is fixed at 16 lanes.
- NUM_REGS, 16, registers per warp per lane.
- NUM_WARPS, 8, warp banks.
- DATA_W, 32, register width.
- ADDR_W, 4, log2(NUM_REGS).
- WARP_W, 3, log2(NUM_WARPS).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- read_en_0  in  16  per-lane read enable, port 0. Bit L is lane L.
- read_en_1  in  16  per-lane read enable, port 1.
- raddr_0  in  4  read register address, port 0, shared by all lanes.
- raddr_1  in  4  read register address, port 1.
- write_en  in  16  per-lane write enable.
- waddr  in  4  write register address, shared by all lanes.
- wdata_0 .. wdata_15  in  32 each  write data, lane 0..15.
- warp_selector  in  3  active warp bank for reads and writes.
- rdata_0_0 .. rdata_0_15  out  32 each  port-0 read data, lane 0..15.
- rdata_1_0 .. rdata_1_15  out  32 each  port-1 read data, lane 0..15.

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous, active-low: on a posedge with rst_n=0, every storage word in all warps and lanes clears to 0.
- Write:
  - Happens on posedge clk when rst_n=1 and write_en[L]=1.
  - Action: mem[L][warp_selector][waddr] <= wdata_L.
  - Lanes with write_en[L]=0 are unchanged.
  - Reset has priority over write.
- Read:
  - Combinational, zero latency. rdata_P_L = mem[L][warp_selector][raddr_P] when read_en_P[L]=1, else 32'h0.
  - Outputs follow address, enable or warp_selector changes within the same cycle.
  - Ports 0 and 1 are fully independent. Both may read the same or different addresses in the same cycle without conflict.
- Read-during-write, same lane, warp and address (no bypass): the read returns the old value until the clock edge, then the new value.
- warp_selector change: takes effect immediately for reads and at the next edge for writes. Other warps' contents are never disturbed.
- Out-of-range values are impossible because widths are exact powers of two.
- Reset value of all outputs: 0 while read_en is 0. If read_en is high during or after reset, outputs read 0 because storage is cleared.
- Reset mid-operation: any write in that cycle is dropped and all storage reads 0 from the next cycle.
- No state machine. Storage is flops or an LUT-RAM style array, one array per lane.

Optional Feature:
- Macro: REGISTER_BLOCK_WRITE_BYPASS_EN.
- Defined: when write_en[L]=1, waddr==raddr_P and read_en_P[L]=1 in the same cycle, rdata_P_L = wdata_L combinationally (write-through forwarding).
- Undefined: no forwarding; the old stored value is returned, as in Behaviour.

Decomposition:
- Package register_block_pkg holds NUM_LANES, NUM_REGS, NUM_WARPS, DATA_W, ADDR_W and WARP_W, plus typedefs reg_addr_t, warp_id_t and word_t.
- One sub-module, register_lane: a single lane's NUM_WARPS x NUM_REGS x DATA_W storage with one write port, two async read ports and output gating.
- register_block instantiates 16 register_lane copies and maps the flat ports onto them.

Test Plan:
- Reset: hold rst_n=0 for one edge, then read_en_0=read_en_1=16'hFFFF for every address in every warp -> all 32 outputs read 32'h0.
- Single write/read:
  - Stimulus: warp_selector=0, waddr=4'h3, write_en=16'hFFFF, wdata_L=32'hA000_0000+L, one edge; then raddr_0=3, read_en_0=16'hFFFF.
  - Response: rdata_0_L=32'hA000_0000+L with no further edge.
  - Then repeat via port 1, and with both ports at address 3 -> identical data on both ports.
- Warp isolation: write 32'h1111_1111 to reg 5 in warp 2 and 32'h2222_2222 to reg 5 in warp 6, all lanes -> warp_selector=2 reads 32'h1111_1111; =6 reads 32'h2222_2222; =0 reads 32'h0.
- Lane masking:
  - Stimulus: write_en=16'h00FF, waddr=7, data 32'hDEAD_BEEF, over reg 7 previously holding 32'h5 in all lanes.
  - Response: lanes 0-7 read 32'hDEAD_BEEF; lanes 8-15 read 32'h5. read_en_0=16'h0F0F -> disabled lanes output 32'h0.
- Full sweep: for all 8 warps x 16 regs, 10 random writes each, all lanes -> after each write, both ports on every lane match the last written data.
- Read-during-write on reg 9, old value 32'h1, writing 32'h2 -> before the edge, port reads 32'h1 without the bypass macro and 32'h2 with it; after the edge, 32'h2 in both builds.

Source files
------------

// File: rtl/register_block_pkg.sv
// Shared sizes and types for the warp-banked SIMT register file.
package register_block_pkg;

  localparam int unsigned NUM_LANES = 16;
  localparam int unsigned NUM_REGS  = 16;
  localparam int unsigned NUM_WARPS = 8;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned WARP_W    = 3;

  typedef logic [ADDR_W-1:0]    reg_addr_t;
  typedef logic [WARP_W-1:0]    warp_id_t;
  typedef logic [DATA_W-1:0]    word_t;
  typedef logic [NUM_LANES-1:0] lane_mask_t;

endpackage

// File: rtl/register_lane.sv
// One lane of the register file: NUM_WARPS x NUM_REGS words, one write port,
// two async gated read ports. Optional forwarding under REGISTER_BLOCK_WRITE_BYPASS_EN.
module register_lane
  import register_block_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  warp_id_t  i_warp,
  input  logic      i_we,
  input  reg_addr_t i_waddr,
  input  word_t     i_wdata,
  input  logic      i_re_0,
  input  reg_addr_t i_raddr_0,
  input  logic      i_re_1,
  input  reg_addr_t i_raddr_1,
  output word_t     o_rdata_0_c,
  output word_t     o_rdata_1_c
);

  word_t r_mem [NUM_WARPS][NUM_REGS];
  word_t w_old_0;
  word_t w_old_1;
  word_t w_sel_0;
  word_t w_sel_1;

  // Reset clears every warp bank and wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
          r_mem[w][r] <= '0;
        end
      end
    end else if (i_we) begin
      r_mem[i_warp][i_waddr] <= i_wdata;
    end
  end

  assign w_old_0 = r_mem[i_warp][i_raddr_0];
  assign w_old_1 = r_mem[i_warp][i_raddr_1];

`ifdef REGISTER_BLOCK_WRITE_BYPASS_EN
  logic w_fwd_0;
  logic w_fwd_1;

  // Forward only data that will actually land, so a write dropped by reset is not seen.
  assign w_fwd_0 = rst_n && i_we && (i_waddr == i_raddr_0);
  assign w_fwd_1 = rst_n && i_we && (i_waddr == i_raddr_1);
  assign w_sel_0 = w_fwd_0 ? i_wdata : w_old_0;
  assign w_sel_1 = w_fwd_1 ? i_wdata : w_old_1;
`else
  assign w_sel_0 = w_old_0;
  assign w_sel_1 = w_old_1;
`endif

  assign o_rdata_0_c = i_re_0 ? w_sel_0 : '0;
  assign o_rdata_1_c = i_re_1 ? w_sel_1 : '0;

endmodule

// File: rtl/register_block.sv
// 16-lane warp-banked register file: maps flat per-lane ports onto register_lane copies.
// Optional write-through forwarding: define REGISTER_BLOCK_WRITE_BYPASS_EN.
module register_block
  import register_block_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  lane_mask_t read_en_0,
  input  lane_mask_t read_en_1,
  input  reg_addr_t  raddr_0,
  input  reg_addr_t  raddr_1,
  input  lane_mask_t write_en,
  input  reg_addr_t  waddr,
  input  word_t      wdata_0,
  input  word_t      wdata_1,
  input  word_t      wdata_2,
  input  word_t      wdata_3,
  input  word_t      wdata_4,
  input  word_t      wdata_5,
  input  word_t      wdata_6,
  input  word_t      wdata_7,
  input  word_t      wdata_8,
  input  word_t      wdata_9,
  input  word_t      wdata_10,
  input  word_t      wdata_11,
  input  word_t      wdata_12,
  input  word_t      wdata_13,
  input  word_t      wdata_14,
  input  word_t      wdata_15,
  input  warp_id_t   warp_selector,
  output word_t      rdata_0_0,
  output word_t      rdata_0_1,
  output word_t      rdata_0_2,
  output word_t      rdata_0_3,
  output word_t      rdata_0_4,
  output word_t      rdata_0_5,
  output word_t      rdata_0_6,
  output word_t      rdata_0_7,
  output word_t      rdata_0_8,
  output word_t      rdata_0_9,
  output word_t      rdata_0_10,
  output word_t      rdata_0_11,
  output word_t      rdata_0_12,
  output word_t      rdata_0_13,
  output word_t      rdata_0_14,
  output word_t      rdata_0_15,
  output word_t      rdata_1_0,
  output word_t      rdata_1_1,
  output word_t      rdata_1_2,
  output word_t      rdata_1_3,
  output word_t      rdata_1_4,
  output word_t      rdata_1_5,
  output word_t      rdata_1_6,
  output word_t      rdata_1_7,
  output word_t      rdata_1_8,
  output word_t      rdata_1_9,
  output word_t      rdata_1_10,
  output word_t      rdata_1_11,
  output word_t      rdata_1_12,
  output word_t      rdata_1_13,
  output word_t      rdata_1_14,
  output word_t      rdata_1_15
);

  word_t w_wdata   [NUM_LANES];
  word_t w_rdata_0 [NUM_LANES];
  word_t w_rdata_1 [NUM_LANES];

  assign w_wdata[0]  = wdata_0;
  assign w_wdata[1]  = wdata_1;
  assign w_wdata[2]  = wdata_2;
  assign w_wdata[3]  = wdata_3;
  assign w_wdata[4]  = wdata_4;
  assign w_wdata[5]  = wdata_5;
  assign w_wdata[6]  = wdata_6;
  assign w_wdata[7]  = wdata_7;
  assign w_wdata[8]  = wdata_8;
  assign w_wdata[9]  = wdata_9;
  assign w_wdata[10] = wdata_10;
  assign w_wdata[11] = wdata_11;
  assign w_wdata[12] = wdata_12;
  assign w_wdata[13] = wdata_13;
  assign w_wdata[14] = wdata_14;
  assign w_wdata[15] = wdata_15;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    register_lane u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_warp      (warp_selector),
      .i_we        (write_en[l]),
      .i_waddr     (waddr),
      .i_wdata     (w_wdata[l]),
      .i_re_0      (read_en_0[l]),
      .i_raddr_0   (raddr_0),
      .i_re_1      (read_en_1[l]),
      .i_raddr_1   (raddr_1),
      .o_rdata_0_c (w_rdata_0[l]),
      .o_rdata_1_c (w_rdata_1[l])
    );
  end

  assign rdata_0_0  = w_rdata_0[0];
  assign rdata_0_1  = w_rdata_0[1];
  assign rdata_0_2  = w_rdata_0[2];
  assign rdata_0_3  = w_rdata_0[3];
  assign rdata_0_4  = w_rdata_0[4];
  assign rdata_0_5  = w_rdata_0[5];
  assign rdata_0_6  = w_rdata_0[6];
  assign rdata_0_7  = w_rdata_0[7];
  assign rdata_0_8  = w_rdata_0[8];
  assign rdata_0_9  = w_rdata_0[9];
  assign rdata_0_10 = w_rdata_0[10];
  assign rdata_0_11 = w_rdata_0[11];
  assign rdata_0_12 = w_rdata_0[12];
  assign rdata_0_13 = w_rdata_0[13];
  assign rdata_0_14 = w_rdata_0[14];
  assign rdata_0_15 = w_rdata_0[15];

  assign rdata_1_0  = w_rdata_1[0];
  assign rdata_1_1  = w_rdata_1[1];
  assign rdata_1_2  = w_rdata_1[2];
  assign rdata_1_3  = w_rdata_1[3];
  assign rdata_1_4  = w_rdata_1[4];
  assign rdata_1_5  = w_rdata_1[5];
  assign rdata_1_6  = w_rdata_1[6];
  assign rdata_1_7  = w_rdata_1[7];
  assign rdata_1_8  = w_rdata_1[8];
  assign rdata_1_9  = w_rdata_1[9];
  assign rdata_1_10 = w_rdata_1[10];
  assign rdata_1_11 = w_rdata_1[11];
  assign rdata_1_12 = w_rdata_1[12];
  assign rdata_1_13 = w_rdata_1[13];
  assign rdata_1_14 = w_rdata_1[14];
  assign rdata_1_15 = w_rdata_1[15];

endmodule

// File: tb/tb_register_block.sv
// Directed, table-driven bench for register_block; honours REGISTER_BLOCK_WRITE_BYPASS_EN.
module tb_register_block;

  logic        clk;
  logic        rst_n;
  logic [15:0] ren0, ren1, wen;
  logic [3:0]  ra0, ra1, wa;
  logic [2:0]  ws;
  logic [31:0] wd  [16];
  wire  [31:0] rd0 [16];
  wire  [31:0] rd1 [16];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  warp;
    logic [3:0]  waddr;
    logic [15:0] wmask;
    logic [31:0] wbase;
    logic        wadd;
    logic [3:0]  raddr;
    logic [15:0] ren0;
    logic [15:0] ren1;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    logic        eadd;
  } vec_t;

  vec_t        vt [11];
  logic [31:0] mdl [8][16][16];
  logic [31:0] e0 [16];
  logic [31:0] e1 [16];

  register_block dut (
    .clk(clk), .rst_n(rst_n),
    .read_en_0(ren0), .read_en_1(ren1), .raddr_0(ra0), .raddr_1(ra1),
    .write_en(wen), .waddr(wa), .warp_selector(ws),
    .wdata_0(wd[0]),   .wdata_1(wd[1]),   .wdata_2(wd[2]),   .wdata_3(wd[3]),
    .wdata_4(wd[4]),   .wdata_5(wd[5]),   .wdata_6(wd[6]),   .wdata_7(wd[7]),
    .wdata_8(wd[8]),   .wdata_9(wd[9]),   .wdata_10(wd[10]), .wdata_11(wd[11]),
    .wdata_12(wd[12]), .wdata_13(wd[13]), .wdata_14(wd[14]), .wdata_15(wd[15]),
    .rdata_0_0(rd0[0]),   .rdata_0_1(rd0[1]),   .rdata_0_2(rd0[2]),   .rdata_0_3(rd0[3]),
    .rdata_0_4(rd0[4]),   .rdata_0_5(rd0[5]),   .rdata_0_6(rd0[6]),   .rdata_0_7(rd0[7]),
    .rdata_0_8(rd0[8]),   .rdata_0_9(rd0[9]),   .rdata_0_10(rd0[10]), .rdata_0_11(rd0[11]),
    .rdata_0_12(rd0[12]), .rdata_0_13(rd0[13]), .rdata_0_14(rd0[14]), .rdata_0_15(rd0[15]),
    .rdata_1_0(rd1[0]),   .rdata_1_1(rd1[1]),   .rdata_1_2(rd1[2]),   .rdata_1_3(rd1[3]),
    .rdata_1_4(rd1[4]),   .rdata_1_5(rd1[5]),   .rdata_1_6(rd1[6]),   .rdata_1_7(rd1[7]),
    .rdata_1_8(rd1[8]),   .rdata_1_9(rd1[9]),   .rdata_1_10(rd1[10]), .rdata_1_11(rd1[11]),
    .rdata_1_12(rd1[12]), .rdata_1_13(rd1[13]), .rdata_1_14(rd1[14]), .rdata_1_15(rd1[15])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string nm, input logic wr, input logic [2:0] warp,
                              input logic [3:0] waddr, input logic [15:0] wmask,
                              input logic [31:0] wbase, input logic wadd,
                              input logic [3:0] raddr, input logic [15:0] r0,
                              input logic [15:0] r1, input logic [31:0] lo,
                              input logic [31:0] hi, input logic eadd);
    vec_t v;
    v.name = nm; v.wr = wr; v.warp = warp; v.waddr = waddr; v.wmask = wmask;
    v.wbase = wbase; v.wadd = wadd; v.raddr = raddr; v.ren0 = r0; v.ren1 = r1;
    v.exp_lo = lo; v.exp_hi = hi; v.eadd = eadd;
    return v;
  endfunction

  task automatic cmp(input string nm, input int port, input int lane,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s port=%0d lane=%0d got=%h exp=%h", nm, port, lane, got, exp);
    end
  endtask

  task automatic chk_all(input string nm);
    for (int l = 0; l < 16; l++) begin
      cmp(nm, 0, l, rd0[l], e0[l]);
      cmp(nm, 1, l, rd1[l], e1[l]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wen = '0; wa = '0; ra0 = '0; ra1 = '0; ren0 = '0; ren1 = '0; ws = '0;
    for (int l = 0; l < 16; l++) wd[l] = '0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset: outputs zero with reads disabled, then every word of every warp reads zero.
    for (int l = 0; l < 16; l++) begin e0[l] = '0; e1[l] = '0; end
    #1;
    chk_all("reset_ren_off");
    ren0 = 16'hFFFF; ren1 = 16'hFFFF;
    for (int w = 0; w < 8; w++) begin
      for (int r = 0; r < 16; r++) begin
        ws = 3'(w); ra0 = 4'(r); ra1 = 4'(15 - r);
        #1;
        chk_all("reset_clear");
      end
    end

    vt[0]  = mk("wr_rd_p0",  1, 0, 3, 16'hFFFF, 32'hA000_0000, 1, 3, 16'hFFFF, 16'h0000, 32'hA000_0000, 32'hA000_0000, 1);
    vt[1]  = mk("rd_p1",     0, 0, 0, 16'h0000, 32'h0,         0, 3, 16'h0000, 16'hFFFF, 32'hA000_0000, 32'hA000_0000, 1);
    vt[2]  = mk("rd_both",   0, 0, 0, 16'h0000, 32'h0,         0, 3, 16'hFFFF, 16'hFFFF, 32'hA000_0000, 32'hA000_0000, 1);
    vt[3]  = mk("warp2_wr",  1, 2, 5, 16'hFFFF, 32'h1111_1111, 0, 5, 16'hFFFF, 16'hFFFF, 32'h1111_1111, 32'h1111_1111, 0);
    vt[4]  = mk("warp6_wr",  1, 6, 5, 16'hFFFF, 32'h2222_2222, 0, 5, 16'hFFFF, 16'hFFFF, 32'h2222_2222, 32'h2222_2222, 0);
    vt[5]  = mk("warp2_iso", 0, 2, 0, 16'h0000, 32'h0,         0, 5, 16'hFFFF, 16'hFFFF, 32'h1111_1111, 32'h1111_1111, 0);
    vt[6]  = mk("warp0_iso", 0, 0, 0, 16'h0000, 32'h0,         0, 5, 16'hFFFF, 16'hFFFF, 32'h0,         32'h0,         0);
    vt[7]  = mk("pre_fill",  1, 0, 7, 16'hFFFF, 32'h5,         0, 7, 16'hFFFF, 16'hFFFF, 32'h5,         32'h5,         0);
    vt[8]  = mk("lane_mask", 1, 0, 7, 16'h00FF, 32'hDEAD_BEEF, 0, 7, 16'hFFFF, 16'hFFFF, 32'hDEAD_BEEF, 32'h5,         0);
    vt[9]  = mk("ren_mask",  0, 0, 0, 16'h0000, 32'h0,         0, 7, 16'h0F0F, 16'hF0F0, 32'hDEAD_BEEF, 32'h5,         0);
    vt[10] = mk("warp6_r3",  0, 6, 0, 16'h0000, 32'h0,         0, 3, 16'hFFFF, 16'hFFFF, 32'h0,         32'h0,         0);

    for (int i = 0; i < 11; i++) begin
      ren0 = '0; ren1 = '0;
      ws = vt[i].warp;
      if (vt[i].wr) begin
        wa  = vt[i].waddr;
        wen = vt[i].wmask;
        for (int l = 0; l < 16; l++) wd[l] = vt[i].wbase + (vt[i].wadd ? 32'(l) : 32'h0);
        tick();
        wen = '0;
      end
      ra0 = vt[i].raddr; ra1 = vt[i].raddr;
      ren0 = vt[i].ren0; ren1 = vt[i].ren1;
      for (int l = 0; l < 16; l++) begin
        logic [31:0] base;
        base  = ((l < 8) ? vt[i].exp_lo : vt[i].exp_hi) + (vt[i].eadd ? 32'(l) : 32'h0);
        e0[l] = vt[i].ren0[l] ? base : 32'h0;
        e1[l] = vt[i].ren1[l] ? base : 32'h0;
      end
      #1;
      chk_all(vt[i].name);
    end

    // Read-during-write on reg 9: port 1 watches reg 3 to show it is untouched.
    ws = 0; wa = 9; wen = 16'hFFFF;
    for (int l = 0; l < 16; l++) wd[l] = 32'h1;
    tick();
    for (int l = 0; l < 16; l++) wd[l] = 32'h2;
    ra0 = 9; ra1 = 3; ren0 = 16'hFFFF; ren1 = 16'hFFFF;
    for (int l = 0; l < 16; l++) begin
`ifdef REGISTER_BLOCK_WRITE_BYPASS_EN
      e0[l] = 32'h2;
`else
      e0[l] = 32'h1;
`endif
      e1[l] = 32'hA000_0000 + 32'(l);
    end
    #1;
    chk_all("rdw_before_edge");
    tick();
    wen = '0;
    for (int l = 0; l < 16; l++) e0[l] = 32'h2;
    #1;
    chk_all("rdw_after_edge");

    // Random sweep from a clean state, tracked by a reference model.
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int w = 0; w < 8; w++)
      for (int r = 0; r < 16; r++)
        for (int l = 0; l < 16; l++) mdl[w][r][l] = '0;
    for (int w = 0; w < 8; w++) begin
      for (int r = 0; r < 16; r++) begin
        for (int k = 0; k < 10; k++) begin
          ren0 = '0; ren1 = '0;
          ws = 3'(w); wa = 4'(r); wen = 16'hFFFF;
          for (int l = 0; l < 16; l++) begin
            wd[l] = $urandom;
            mdl[w][r][l] = wd[l];
          end
          tick();
          wen = '0;
          ra0 = 4'(r); ra1 = 4'(r); ren0 = 16'hFFFF; ren1 = 16'hFFFF;
          for (int l = 0; l < 16; l++) begin e0[l] = mdl[w][r][l]; e1[l] = mdl[w][r][l]; end
          #1;
          chk_all("sweep_wr");
        end
      end
    end
    for (int w = 0; w < 8; w++) begin
      for (int r = 0; r < 16; r++) begin
        ws = 3'(w); ra0 = 4'(r); ra1 = 4'(15 - r);
        for (int l = 0; l < 16; l++) begin e0[l] = mdl[w][r][l]; e1[l] = mdl[w][15 - r][l]; end
        #1;
        chk_all("sweep_scan");
      end
    end

    // Reset mid-operation: the concurrent write is dropped and storage reads zero.
    ws = 1; wa = 0; wen = 16'hFFFF;
    for (int l = 0; l < 16; l++) wd[l] = 32'hCAFE_0000 + 32'(l);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; wen = '0;
    for (int l = 0; l < 16; l++) begin e0[l] = '0; e1[l] = '0; end
    ra0 = 0; ra1 = 15;
    #1;
    chk_all("midop_reset_w1");
    ws = 7;
    #1;
    chk_all("midop_reset_w7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
